// File: rtl/afu_port_flr_seq_if.sv
// FLR request/response and per-port gating/reset bundle between the
// FLR request source, the sequencer and the per-port TX/reset logic.
//
// Handshake semantics:
//   flr_req_*  : a strobe with no ready. Every cycle flr_req_valid is high,
//                flr_req_port is sampled at that clock edge.
//   flr_rsp_*  : a strict valid/ready pair. Once flr_rsp_valid rises, it and
//                flr_rsp_port hold stable until a cycle where flr_rsp_ready is
//                also high. The transfer completes at that clock edge.
interface afu_port_flr_seq_if #(
  parameter int NUM_PORTS = 8,
  parameter int PORT_ID_W = $clog2(NUM_PORTS)
);
  logic                 flr_req_valid;
  logic [PORT_ID_W-1:0] flr_req_port;
  logic                 flr_rsp_valid;
  logic [PORT_ID_W-1:0] flr_rsp_port;
  logic                 flr_rsp_ready;
  logic [NUM_PORTS-1:0] tx_pkt_active;
  logic [NUM_PORTS-1:0] tx_gate;
  logic [NUM_PORTS-1:0] port_rst;

  // Request source / port logic side
  modport master (
    output flr_req_valid, flr_req_port, flr_rsp_ready, tx_pkt_active,
    input  flr_rsp_valid, flr_rsp_port, tx_gate, port_rst
  );

  // Sequencer side
  modport slave (
    input  flr_req_valid, flr_req_port, flr_rsp_ready, tx_pkt_active,
    output flr_rsp_valid, flr_rsp_port, tx_gate, port_rst
  );
endinterface

// File: rtl/afu_port_flr_seq.sv
// Per-port function-level-reset sequencer. Pending FLR requests are
// serviced one port at a time in round-robin order. Each service gates new
// TX packet starts, waits for the in-flight packet to drain (bounded),
// holds the port reset for a fixed time, then reports completion.
module afu_port_flr_seq #(
  parameter int NUM_PORTS       = 8,
  parameter int PORT_ID_W       = $clog2(NUM_PORTS),
  parameter int RST_HOLD_CYCLES = 16,
  parameter int DRAIN_TIMEOUT   = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  afu_port_flr_seq_if.slave         bus,
  output logic                      busy,
  output logic                      drain_timeout_err,
  output logic                      bad_port_err,
  output logic [1:0]                state_dbg
);

  localparam int MAX_CNT = (DRAIN_TIMEOUT > RST_HOLD_CYCLES) ? DRAIN_TIMEOUT : RST_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RESET = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [NUM_PORTS-1:0] pending, pending_nxt;
  logic [PORT_ID_W-1:0] rr_ptr, rr_nxt;
  logic [PORT_ID_W-1:0] cur_port, cur_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 rsp_valid;

  logic                 req_ok, req_bad;
  logic                 grant_found;
  logic [PORT_ID_W-1:0] grant_idx;
  int                   arb_idx;
  logic                 timeout_hit;
  logic [NUM_PORTS-1:0] clr_mask, set_mask;

  function automatic logic [NUM_PORTS-1:0] port_mask(input logic [PORT_ID_W-1:0] p);
    port_mask    = '0;
    port_mask[p] = 1'b1;
  endfunction

  // Classify the incoming request as in-range or out-of-range
  always_comb begin
    req_ok  = bus.flr_req_valid && (int'(bus.flr_req_port) < NUM_PORTS);
    req_bad = bus.flr_req_valid && !(int'(bus.flr_req_port) < NUM_PORTS);
  end

  // Round-robin search of pending bits starting at rr_ptr, wrapping to 0
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_idx     = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      arb_idx = int'(rr_ptr) + i;
      if (arb_idx >= NUM_PORTS) arb_idx = arb_idx - NUM_PORTS;
      if (!grant_found && pending[PORT_ID_W'(arb_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = PORT_ID_W'(arb_idx);
      end
    end
  end

  // Next-state, counter, grant and pending update
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cur_nxt     = cur_port;
    rr_nxt      = rr_ptr;
    timeout_hit = 1'b0;
    clr_mask    = '0;
    set_mask    = req_ok ? port_mask(bus.flr_req_port) : '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          clr_mask  = port_mask(grant_idx);
          cur_nxt   = grant_idx;
          cnt_nxt   = '0;
          rr_nxt    = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.tx_pkt_active[cur_port]) begin
          state_nxt = RESET;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(DRAIN_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = RESET;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESET: begin
        if (cnt == CNT_W'(RST_HOLD_CYCLES - 1)) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_valid && bus.flr_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A new request to the bit being granted this cycle survives the clear
    pending_nxt = (pending & ~clr_mask) | set_mask;
  end

  // State registers and registered per-port outputs derived from next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      pending           <= '0;
      rr_ptr            <= '0;
      cur_port          <= '0;
      cnt               <= '0;
      rsp_valid         <= 1'b0;
      bus.tx_gate       <= '0;
      bus.port_rst      <= '0;
      drain_timeout_err <= 1'b0;
      bad_port_err      <= 1'b0;
    end else begin
      state             <= state_nxt;
      pending           <= pending_nxt;
      rr_ptr            <= rr_nxt;
      cur_port          <= cur_nxt;
      cnt               <= cnt_nxt;
      rsp_valid         <= (state_nxt == RESP);
      bus.tx_gate       <= (state_nxt != IDLE)  ? port_mask(cur_nxt) : '0;
      bus.port_rst      <= (state_nxt == RESET) ? port_mask(cur_nxt) : '0;
      drain_timeout_err <= timeout_hit;
      bad_port_err      <= req_bad;
    end
  end

  assign bus.flr_rsp_valid = rsp_valid;
  assign bus.flr_rsp_port  = cur_port;
  assign busy              = (state != IDLE) || (pending != '0);
  assign state_dbg         = state;

endmodule

// File: tb/tb_afu_port_flr_seq.sv
// Directed bench for afu_port_flr_seq. Instance A uses the default
// configuration; instance B (6 ports, 8-cycle drain timeout) covers the
// timeout path and out-of-range port requests.
module tb_afu_port_flr_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  afu_port_flr_seq_if #(.NUM_PORTS(8)) a_if ();
  afu_port_flr_seq_if #(.NUM_PORTS(6)) b_if ();

  logic       busy_a, to_err_a, bad_err_a;
  logic [1:0] state_a;
  logic       busy_b, to_err_b, bad_err_b;
  logic [1:0] state_b;

  afu_port_flr_seq #(
    .NUM_PORTS(8), .RST_HOLD_CYCLES(16), .DRAIN_TIMEOUT(1024)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave),
    .busy(busy_a), .drain_timeout_err(to_err_a),
    .bad_port_err(bad_err_a), .state_dbg(state_a)
  );

  afu_port_flr_seq #(
    .NUM_PORTS(6), .RST_HOLD_CYCLES(16), .DRAIN_TIMEOUT(8)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave),
    .busy(busy_b), .drain_timeout_err(to_err_b),
    .bad_port_err(bad_err_b), .state_dbg(state_b)
  );

  localparam logic [1:0] S_IDLE = 2'd0, S_DRAIN = 2'd1, S_RESET = 2'd2, S_RESP = 2'd3;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int oh_viol  = 0;
  int rst_cycles, to_pulses;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // At most one gated/reset port, and reset only on the gated port
  always @(negedge clk) begin
    if (!rst) begin
      if (!$onehot0(a_if.tx_gate) || !$onehot0(a_if.port_rst) ||
          ((a_if.port_rst & ~a_if.tx_gate) != '0)) oh_viol++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_a(input logic [2:0] p);
    a_if.flr_req_valid = 1'b1;
    a_if.flr_req_port  = p;
    @(negedge clk);
    a_if.flr_req_valid = 1'b0;
  endtask

  task automatic send_b(input logic [2:0] p);
    b_if.flr_req_valid = 1'b1;
    b_if.flr_req_port  = p;
    @(negedge clk);
    b_if.flr_req_valid = 1'b0;
  endtask

  task automatic wait_rst_bit_a(input int b, input int max);
    int n = 0;
    while (!a_if.port_rst[b] && n < max) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("wait_port_rst_%0d", b), 32'(a_if.port_rst[b]), 32'd1);
  endtask

  // Runs until A raises a response; counts reset-hold cycles and timeout pulses
  task automatic wait_rsp_a(input int max, output logic [2:0] port);
    int n = 0;
    rst_cycles = 0;
    to_pulses  = 0;
    while (!a_if.flr_rsp_valid && n < max) begin
      @(negedge clk);
      n++;
      if (a_if.port_rst != '0) rst_cycles++;
      if (to_err_a) to_pulses++;
    end
    check("rsp_arrives", 32'(a_if.flr_rsp_valid), 32'd1);
    port = a_if.flr_rsp_port;
  endtask

  task automatic handshake_a();
    a_if.flr_rsp_ready = 1'b1;
    @(negedge clk);
    a_if.flr_rsp_ready = 1'b0;
    check("post_hs_gate", 32'(a_if.tx_gate), 32'd0);
    check("post_hs_valid", 32'(a_if.flr_rsp_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] p;
    int cnt, bad, e, r, n, seen;

    a_if.flr_req_valid = 1'b0; a_if.flr_req_port = '0;
    a_if.flr_rsp_ready = 1'b0; a_if.tx_pkt_active = '0;
    b_if.flr_req_valid = 1'b0; b_if.flr_req_port = '0;
    b_if.flr_rsp_ready = 1'b0; b_if.tx_pkt_active = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gate",  32'(a_if.tx_gate), 32'd0);
    check("rst_prst",  32'(a_if.port_rst), 32'd0);
    check("rst_valid", 32'(a_if.flr_rsp_valid), 32'd0);
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_state", 32'(state_a), 32'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Idle port 3, full latency walk
    send_a(3'd3);                         // now after capture edge 0
    check("t1_busy_pending", 32'(busy_a), 32'd1);
    check("t1_gate_c0", 32'(a_if.tx_gate), 32'd0);
    @(negedge clk);                       // cycle 1
    check("t1_gate_c1", 32'(a_if.tx_gate), 32'h08);
    check("t1_prst_c1", 32'(a_if.port_rst), 32'd0);
    check("t1_state_c1", 32'(state_a), 32'(S_DRAIN));
    cnt = 0;
    repeat (16) begin                     // cycles 2..17
      @(negedge clk);
      if (a_if.port_rst == 8'h08) cnt++;
    end
    check("t1_rst_hold", 32'(cnt), 32'd16);
    @(negedge clk);                       // cycle 18
    check("t1_prst_c18", 32'(a_if.port_rst), 32'd0);
    check("t1_valid_c18", 32'(a_if.flr_rsp_valid), 32'd1);
    check("t1_port_c18", 32'(a_if.flr_rsp_port), 32'd3);
    check("t1_gate_c18", 32'(a_if.tx_gate), 32'h08);
    handshake_a();                        // cycle 19
    check("t1_busy_c19", 32'(busy_a), 32'd0);

    // Drain wait on port 2
    a_if.tx_pkt_active = 8'h04;
    send_a(3'd2);
    cnt = 0;
    repeat (38) begin
      @(negedge clk);
      if (a_if.port_rst != '0) cnt++;
    end
    check("drain_no_early_rst", 32'(cnt), 32'd0);
    check("drain_gate", 32'(a_if.tx_gate), 32'h04);
    check("drain_state", 32'(state_a), 32'(S_DRAIN));
    a_if.tx_pkt_active = '0;
    wait_rsp_a(40, p);
    check("drain_rsp_port", 32'(p), 32'd2);
    check("drain_rst_cycles", 32'(rst_cycles), 32'd16);
    check("drain_no_timeout", 32'(to_pulses), 32'd0);
    handshake_a();

    // Round robin: serve port 1 so the pointer sits at 2, queue 6,1,4
    send_a(3'd1);
    wait_rst_bit_a(1, 10);
    send_a(3'd6);
    send_a(3'd1);
    send_a(3'd4);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd4);
    wait_rsp_a(40, p);
    check("rr_order_0", 32'(p), exp_q.pop_front());
    handshake_a();
    wait_rst_bit_a(4, 10);
    send_a(3'd4);                         // repeat request during own RESET
    wait_rsp_a(40, p);
    check("rr_order_1", 32'(p), exp_q.pop_front());
    // Backpressure: response and gate hold, nothing else is granted
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_if.flr_rsp_valid !== 1'b1 || a_if.flr_rsp_port !== 3'd4 ||
          a_if.tx_gate !== 8'h10 || a_if.port_rst !== 8'h00 ||
          state_a !== S_RESP) bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    handshake_a();
    wait_rsp_a(40, p);
    check("rr_order_2", 32'(p), exp_q.pop_front());
    check("rr_rst_cycles", 32'(rst_cycles), 32'd16);
    handshake_a();
    wait_rsp_a(40, p);
    check("rr_order_3", 32'(p), exp_q.pop_front());
    handshake_a();
    wait_rsp_a(40, p);
    check("rr_order_4", 32'(p), exp_q.pop_front());
    handshake_a();
    @(negedge clk);
    check("rr_idle_busy", 32'(busy_a), 32'd0);

    // Reset in the middle of RESET on port 0 with port 5 pending
    send_a(3'd0);
    wait_rst_bit_a(0, 10);
    send_a(3'd5);
    #2 rst = 1'b1;
    #1;
    check("arst_prst", 32'(a_if.port_rst), 32'd0);
    check("arst_gate", 32'(a_if.tx_gate), 32'd0);
    check("arst_valid", 32'(a_if.flr_rsp_valid), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_if.flr_rsp_valid || a_if.tx_gate != '0 || busy_a) seen++;
    end
    check("arst_no_service", 32'(seen), 32'd0);

    // Instance B: drain timeout with port 5 stuck active
    b_if.tx_pkt_active = 6'b100000;
    send_b(3'd5);                         // after edge 0
    e = 0; r = 0;
    repeat (8) begin                      // DRAIN cycles 1..8
      @(negedge clk);
      if (to_err_b) e++;
      if (b_if.port_rst != '0) r++;
    end
    check("to_no_early_err", 32'(e), 32'd0);
    check("to_no_early_rst", 32'(r), 32'd0);
    check("to_state_drain", 32'(state_b), 32'(S_DRAIN));
    @(negedge clk);                       // cycle 9
    check("to_pulse", 32'(to_err_b), 32'd1);
    check("to_prst", 32'(b_if.port_rst), 32'h20);
    r = 1; e = 0; n = 0;
    while (!b_if.flr_rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (to_err_b) e++;
      if (b_if.port_rst != '0) r++;
    end
    check("to_single_pulse", 32'(e), 32'd0);
    check("to_rst_cycles", 32'(r), 32'd16);
    check("to_rsp_valid", 32'(b_if.flr_rsp_valid), 32'd1);
    check("to_rsp_port", 32'(b_if.flr_rsp_port), 32'd5);
    b_if.flr_rsp_ready = 1'b1;
    @(negedge clk);
    b_if.flr_rsp_ready = 1'b0;
    b_if.tx_pkt_active = '0;
    check("to_done_busy", 32'(busy_b), 32'd0);

    // Instance B: out-of-range ports are dropped
    send_b(3'd7);
    check("bad7_pulse", 32'(bad_err_b), 32'd1);
    check("bad7_busy", 32'(busy_b), 32'd0);
    @(negedge clk);
    check("bad7_pulse_end", 32'(bad_err_b), 32'd0);
    send_b(3'd6);
    check("bad6_pulse", 32'(bad_err_b), 32'd1);
    @(negedge clk);
    check("bad6_state", 32'(state_b), 32'(S_IDLE));
    check("bad6_gate", 32'(b_if.tx_gate), 32'd0);
    check("a_no_bad_err", 32'(bad_err_a), 32'd0);

    check("onehot_gate_rst", 32'(oh_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog in case a wait escapes its bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
